// File: rtl/ex_mem_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg_if
//   Bundles the EX-side input channel and the MEM-side output channel of the
//   EX->MEM pipeline register.
//
//   Handshake: a beat moves on a channel at a rising clk edge when its valid
//   and ready are both high at that edge. Valid does not wait on ready. The
//   producer keeps the payload stable while valid is high and ready is low.
//
//   Modports
//     slave  : the pipeline register (receives in_*, drives out_*).
//     master : the EX/MEM environment (drives in_*, receives out_*).
//   Signals
//     in_valid/in_ready, in_ctrl, in_branch_pc, in_zero, in_aluresult,
//     in_readda2, in_writereg           EX -> register
//     out_valid/out_ready, out_ctrl, out_branch_pc, out_zero, out_aluresult,
//     out_readda2, out_writereg         register -> MEM
//     skid_valid                        debug: skid entry occupied
// ---------------------------------------------------------------------------
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_branch_pc;
    logic              in_zero;
    logic [DATA_W-1:0] in_aluresult;
    logic [DATA_W-1:0] in_readda2;
    logic [REG_AW-1:0] in_writereg;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_branch_pc;
    logic              out_zero;
    logic [DATA_W-1:0] out_aluresult;
    logic [DATA_W-1:0] out_readda2;
    logic [REG_AW-1:0] out_writereg;

    logic              skid_valid;

    modport slave (
        input  in_valid, in_ctrl, in_branch_pc, in_zero, in_aluresult,
               in_readda2, in_writereg, out_ready,
        output in_ready, out_valid, out_ctrl, out_branch_pc, out_zero,
               out_aluresult, out_readda2, out_writereg, skid_valid
    );

    modport master (
        output in_valid, in_ctrl, in_branch_pc, in_zero, in_aluresult,
               in_readda2, in_writereg, out_ready,
        input  in_ready, out_valid, out_ctrl, out_branch_pc, out_zero,
               out_aluresult, out_readda2, out_writereg, skid_valid
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
//   EX->MEM pipeline register with valid/ready handshake, a 2-entry skid
//   buffer (main + skid) for back-pressure and a synchronous flush.
//   Control bits of an empty slot read as zero so a bubble never writes
//   memory or the register file.
//
//   Ports
//     clk      rising-edge clock
//     rst_n    synchronous active-low reset
//     flush    drop both held entries and the input of this cycle
//     bus      ex_mem_pipe_reg_if.slave (EX input channel, MEM output
//              channel, skid_valid debug)
//     stall_cnt [31:0]  only with EX_MEM_STALL_CNT_EN: saturating count of
//              cycles with out_valid=1 and out_ready=0, cleared by reset only
//
//   Optional feature macro: EX_MEM_STALL_CNT_EN
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    ex_mem_pipe_reg_if.slave    bus
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);
    // Payload packed as {ctrl, branch_pc, zero, aluresult, readda2, writereg}.
    localparam int PW = CTRL_W + 3 * DATA_W + 1 + REG_AW;

    logic [PW-1:0]     in_pl;
    logic [PW-1:0]     main_q, main_d;
    logic [PW-1:0]     skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] ctrl_st;

    logic accept;
    logic consume;
    logic main_free;

    assign in_pl = {bus.in_ctrl, bus.in_branch_pc, bus.in_zero,
                    bus.in_aluresult, bus.in_readda2, bus.in_writereg};

    // in_ready comes straight from a flop: the skid is the only overflow room.
    assign bus.in_ready = ~skid_valid_q;
    assign accept       = bus.in_valid & ~skid_valid_q;
    assign consume      = out_valid_q & bus.out_ready;
    assign main_free    = ~out_valid_q | consume;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payload is left alone; only the valid bits are dropped.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no accept can collide with this move.
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d      = in_pl;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign {ctrl_st, bus.out_branch_pc, bus.out_zero, bus.out_aluresult,
            bus.out_readda2, bus.out_writereg} = main_q;
    assign bus.out_ctrl   = ctrl_st & {CTRL_W{out_valid_q}};
    assign bus.out_valid  = out_valid_q;
    assign bus.skid_valid = skid_valid_q;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Deliberately not cleared by flush: it is a performance statistic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
//   Directed bench for ex_mem_pipe_reg. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge. Accepted beats are pushed
//   to exp_q; the monitor pops and compares whenever MEM consumes a beat.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 5;
    localparam int PW     = CTRL_W + 3 * DATA_W + 1 + REG_AW;

    logic clk;
    logic rst_n;
    logic flush;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    ex_mem_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) bus ();

    ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus.slave)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [PW-1:0] mk(input logic [31:0] v, input logic [4:0] c);
        logic [31:0] pc;
        pc = v + 32'h100;
        return {c, pc, v[0], v, ~v, v[4:0]};
    endfunction

    function automatic logic [PW-1:0] out_pl();
        return {bus.out_ctrl, bus.out_branch_pc, bus.out_zero, bus.out_aluresult,
                bus.out_readda2, bus.out_writereg};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic [31:0] v, input logic [4:0] c);
        {bus.in_ctrl, bus.in_branch_pc, bus.in_zero, bus.in_aluresult,
         bus.in_readda2, bus.in_writereg} = mk(v, c);
        bus.in_valid = 1'b1;
    endtask

    // Presents a beat and waits (bounded) for it to be accepted; in_valid stays
    // high afterwards so callers can stream back-to-back.
    task automatic send(input logic [31:0] v, input logic [4:0] c);
        bit done;
        done = 0;
        drive_in(v, c);
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(mk(v, c));
                done = 1;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: value %0h never accepted", v);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", bus.out_aluresult);
            end else begin
                check("sb_payload", 128'(out_pl()), 128'(exp_q.pop_front()));
            end
        end
        if (bus.out_valid === 1'b0) begin
            check("bubble_ctrl_zero", 128'(bus.out_ctrl), 128'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(32'hDEAD, 5'b11111);   // must be ignored during reset

        // Reset
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_ctrl", 128'(bus.out_ctrl), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_payload", 128'(out_pl()), 128'd0);
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Back-to-back stream, 1-cycle latency
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive_in(k, 5'b01100);
            @(negedge clk);
            check("stream_in_ready", 128'(bus.in_ready), 128'd1);
            if (k > 1) begin
                check("stream_latency", 128'({bus.out_valid, bus.out_aluresult}),
                      128'({1'b1, 32'(k - 1)}));
            end
            exp_q.push_back(mk(k, 5'b01100));
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stream_last", 128'({bus.out_valid, bus.out_aluresult}), 128'({1'b1, 32'd4}));
        tick();
        @(negedge clk);
        check("stream_drained", 128'(bus.out_valid), 128'd0);
        tick();

        // Stall fill: two entries held
        bus.out_ready = 1'b0;
        send(32'hA, 5'b10010);
        send(32'hB, 5'b10010);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fill_in_ready_low", 128'(bus.in_ready), 128'd0);
        check("fill_hold_a", 128'({bus.out_valid, bus.out_aluresult}), 128'({1'b1, 32'hA}));
        tick();
        @(negedge clk);
        check("fill_stable_a", 128'(out_pl()), 128'(mk(32'hA, 5'b10010)));
        tick();
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("fill_then_b", 128'({bus.in_ready, bus.out_valid, bus.out_aluresult}),
              128'({1'b1, 1'b1, 32'hB}));
        tick();
        tick();

        // Flush with full skid; the flush-cycle input is dropped
        bus.out_ready = 1'b0;
        send(32'h11, 5'b01000);
        send(32'h12, 5'b01000);
        drive_in(32'hC, 5'b01000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_state", 128'({bus.out_valid, bus.out_ctrl, bus.in_ready, bus.skid_valid}),
              128'({1'b0, 5'b00000, 1'b1, 1'b0}));
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Consume and accept in the same cycle with an empty skid
        bus.out_ready = 1'b0;
        send(32'h20, 5'b00110);
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        send(32'hD, 5'b00110);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("cons_acc_out", 128'({bus.out_valid, bus.out_aluresult}), 128'({1'b1, 32'hD}));
        check("cons_acc_skid", 128'({bus.skid_valid, bus.in_ready}), 128'({1'b0, 1'b1}));
        tick();
        tick();

        // Reset in the middle of a stall
        bus.out_ready = 1'b0;
        send(32'h30, 5'b11000);
        send(32'h31, 5'b11000);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_full", 128'(bus.in_ready), 128'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_outputs", 128'({bus.out_valid, out_pl()}), 128'd0);
        check("mid_rst_ready", 128'({bus.in_ready, bus.skid_valid}), 128'({1'b1, 1'b0}));
`ifdef EX_MEM_STALL_CNT_EN
        check("mid_rst_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
        tick();

`ifdef EX_MEM_STALL_CNT_EN
        // Stall counter: 7 stalled edges, then a flush with a consume
        bus.out_ready = 1'b0;
        send(32'h40, 5'b00001);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("stall_cnt_7", 128'(stall_cnt), 128'd7);
        #1;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("stall_cnt_after_flush", 128'(stall_cnt), 128'd7);
        tick();
`endif

        // Everything pushed must have been consumed
        repeat (3) tick();
        check("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
